// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle RV32 controller:
// opcodes, ALU operation codes and FSM state encoding.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Maps {opcode, funct3, funct7[5]} to an ALU operation
// and flags encodings the controller does not support.
module alu_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    logic [3:0] key;
    logic [3:0] map_ctrl;
    logic       map_ok;
    logic       is_r;

    assign is_r = (opcode == OP_R);
    // Immediate forms only look at funct7[5] for the shift-right pair.
    assign key = {funct7_b5 & (is_r | (funct3 == 3'b101)), funct3};

    always_comb begin
        map_ctrl = ALU_ADD;
        map_ok   = 1'b1;
        case (key)
            4'b0000: map_ctrl = ALU_ADD;
            4'b1000: map_ctrl = ALU_SUB;
            4'b0111: map_ctrl = ALU_AND;
            4'b0110: map_ctrl = ALU_OR;
            4'b0100: map_ctrl = ALU_XOR;
            4'b0010: map_ctrl = ALU_SLT;
            4'b0001: map_ctrl = ALU_SLL;
            4'b0101: map_ctrl = ALU_SRL;
            4'b1101: map_ctrl = ALU_SRA;
            default: map_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        unique case (1'b1)
            (opcode == OP_R), (opcode == OP_I): begin
                alu_ctrl = map_ctrl;
                legal    = map_ok;
            end
            (opcode == OP_LOAD), (opcode == OP_STORE): begin
                alu_ctrl = ALU_ADD;
                legal    = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                alu_ctrl = ALU_SUB;
                legal    = (funct3 == 3'b000);
            end
            default: begin
                alu_ctrl = ALU_ADD;
                legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the single-ALU RV32
// datapath, with sticky fault flag and retired-instruction count.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_in,
    input  logic                 iReady,
    input  logic                 dReady,
    input  logic                 Zero,
    output logic                 iReq,
    output logic [31:0]          instr,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MemToReg,
    output logic [3:0]           ALUCtrl,
    output logic                 loadPC,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_n;
    logic             run;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting, timeout;
    logic             retire, set_fault;
    logic [3:0]       dec_alu;
    logic             dec_legal;
    logic             is_r, is_load, is_store, is_branch;

    alu_decode u_dec (
        .opcode    (instr[6:0]),
        .funct3    (instr[14:12]),
        .funct7_b5 (instr[30]),
        .alu_ctrl  (dec_alu),
        .legal     (dec_legal)
    );

    assign is_r      = (instr[6:0] == OP_R);
    assign is_load   = (instr[6:0] == OP_LOAD);
    assign is_store  = (instr[6:0] == OP_STORE);
    assign is_branch = (instr[6:0] == OP_BRANCH);

    // run holds off the first fetch request until one edge after reset.
    assign waiting = ((state == S_IF) && run && !iReady)
                   || ((state == S_MEM) && !dReady);
    assign timeout = waiting && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IF;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        iReq      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        PCSrc     = 1'b0;
        ALUSrc    = 1'b0;
        RegWrite  = 1'b0;
        MemToReg  = 1'b0;
        ALUCtrl   = ALU_AND;
        loadPC    = 1'b0;
        retire    = 1'b0;
        set_fault = timeout;
        unique case (state)
            S_IF: begin
                iReq = run;
                if (run && iReady) state_n = S_ID;
            end
            S_ID: begin
                if (!dec_legal) begin
                    set_fault = 1'b1;
                    loadPC    = 1'b1;
                    state_n   = S_IF;
                end else begin
                    state_n = S_EX;
                end
            end
            S_EX: begin
                ALUCtrl = dec_alu;
                ALUSrc  = !is_r && !is_branch;
                if (is_branch) begin
                    loadPC  = 1'b1;
                    PCSrc   = Zero;
                    retire  = 1'b1;
                    state_n = S_IF;
                end else if (is_load || is_store) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                ALUCtrl  = dec_alu;
                ALUSrc   = 1'b1;
                MemRead  = is_load;
                MemWrite = is_store;
                if (dReady) begin
                    if (is_store) begin
                        loadPC  = 1'b1;
                        retire  = 1'b1;
                        state_n = S_IF;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (timeout) begin
                    state_n = S_IF;
                end
            end
            S_WB: begin
                ALUCtrl  = dec_alu;
                ALUSrc   = !is_r;
                RegWrite = 1'b1;
                MemToReg = is_load;
                loadPC   = 1'b1;
                retire   = 1'b1;
                state_n  = S_IF;
            end
            default: state_n = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            instr    <= INSTR_NOP;
            fault    <= 1'b0;
            instret  <= '0;
            wait_cnt <= '0;
        end else begin
            run <= 1'b1;
            if ((state == S_IF) && run && iReady) instr <= instr_in;
            if (set_fault) fault <= 1'b1;
            if (retire) instret <= instret + 1'b1;
            wait_cnt <= (waiting && !timeout) ? wait_cnt + 1'b1 : '0;
        end
    end

endmodule
